// File: rtl/vector_packer_1x20.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// vector_packer_1x20 : packs a valid/ready element stream into MSB-first vectors
// Revision 1.0
// ============================================================================
module vector_packer_1x20 #(
  parameter int VEC_SIZE  = 20,
  parameter int BW        = 32,
  parameter int FRAC_BITS = 20
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [BW-1:0]               s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic                        s_last,
  output logic [VEC_SIZE*BW-1:0]      vec_bus,
  output logic                        vec_valid,
  input  logic                        vec_ready,
  output logic                        frame_err,
  output logic [$clog2(VEC_SIZE)-1:0] elem_count
);

  localparam int            CW   = $clog2(VEC_SIZE);
  localparam logic [CW-1:0] LAST = CW'(VEC_SIZE - 1);

  // Data is copied bit-exact; the fractional split only has to fit in an element.
  if (FRAC_BITS >= BW) begin : g_frac_bits_exceed_width
  end

  logic [VEC_SIZE*BW-1:0] fill;
  logic [VEC_SIZE*BW-1:0] merged;
  logic [CW-1:0]          cnt;
  logic                   fill_full;
  logic                   in_xfer;
  logic                   out_free;

  assign s_ready    = !fill_full && !rst;
  assign in_xfer    = s_valid && s_ready;
  assign out_free   = !vec_valid || vec_ready;
  assign elem_count = cnt;

  // Fill buffer with the incoming element dropped into slot cnt (slot 0 in the MSBs).
  always_comb begin
    merged = fill;
    for (int i = 0; i < VEC_SIZE; i++) begin
      if (cnt == CW'(i)) begin
        merged[(VEC_SIZE-1-i)*BW +: BW] = s_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill      <= '0;
      cnt       <= '0;
      fill_full <= 1'b0;
      vec_bus   <= '0;
      vec_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (vec_valid && vec_ready) begin
        vec_valid <= 1'b0;
      end
      // A held vector moves out as soon as the output register frees up.
      if (fill_full && out_free) begin
        vec_bus   <= fill;
        vec_valid <= 1'b1;
        fill_full <= 1'b0;
      end
      // in_xfer implies !fill_full, so this never collides with the move above.
      if (in_xfer) begin
        if (cnt != LAST) begin
          if (s_last) begin
            frame_err <= 1'b1;
            cnt       <= '0;
          end else begin
            fill <= merged;
            cnt  <= cnt + CW'(1);
          end
        end else begin
          cnt <= '0;
          if (!s_last) begin
            frame_err <= 1'b1;
          end else if (out_free) begin
            vec_bus   <= merged;
            vec_valid <= 1'b1;
          end else begin
            fill      <= merged;
            fill_full <= 1'b1;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vector_packer_1x20.sv
`timescale 1ns/1ps
`default_nettype none
// Directed bench for vector_packer_1x20: hand-built vectors checked against captured output.
module tb_vector_packer_1x20;

  localparam int VS = 20;
  localparam int BW = 32;
  localparam int CW = $clog2(VS);
  localparam int VW = VS * BW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [BW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          s_last = 1'b0;
  logic [VW-1:0] vec_bus;
  logic          vec_valid;
  logic          vec_ready = 1'b0;
  logic          frame_err;
  logic [CW-1:0] elem_count;

  vector_packer_1x20 #(.VEC_SIZE(VS), .BW(BW), .FRAC_BITS(20)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_last     (s_last),
    .vec_bus    (vec_bus),
    .vec_valid  (vec_valid),
    .vec_ready  (vec_ready),
    .frame_err  (frame_err),
    .elem_count (elem_count)
  );

  always #5 clk = ~clk;

  int            n_total = 0;
  int            n_bad   = 0;
  int            cyc     = 0;
  int            ferr_n  = 0;
  int            vv_n    = 0;
  logic [VW-1:0] got_q[$];
  int            got_cyc[$];
  logic [BW-1:0] ev[VS];

  // Outputs are observed on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      if (vec_valid && vec_ready) begin
        got_q.push_back(vec_bus);
        got_cyc.push_back(cyc);
      end
      if (frame_err) ferr_n <= ferr_n + 1;
      if (vec_valid) vv_n <= vv_n + 1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] pack_ev();
    logic [VW-1:0] v;
    for (int i = 0; i < VS; i++) v[(VS-1-i)*BW +: BW] = ev[i];
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [BW-1:0] d, input logic l);
    int w;
    w = 0;
    s_data  = d;
    s_valid = 1'b1;
    s_last  = l;
    @(negedge clk);
    while (!s_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!s_ready) chk("send_ready_timeout", VW'(s_ready), VW'(1));
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // last_at < 0 sends a frame with no s_last at all.
  task automatic send_vec(input int last_at);
    for (int i = 0; i < VS; i++) send(ev[i], i == last_at);
  endtask

  int            b;
  int            f0;
  int            v0;
  logic [VW-1:0] exp_a;
  logic [VW-1:0] exp_b;
  logic [VW-1:0] t;

  initial begin
    // ---- reset state ----
    tick(3);
    chk("rst_vec_valid", VW'(vec_valid), VW'(0));
    chk("rst_vec_bus", vec_bus, VW'(0));
    chk("rst_elem_count", VW'(elem_count), VW'(0));
    chk("rst_frame_err", VW'(frame_err), VW'(0));
    chk("rst_s_ready", VW'(s_ready), VW'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("s_ready_after_rst", VW'(s_ready), VW'(1));
    tick(1);

    // ---- basic fill ----
    vec_ready = 1'b1;
    b = got_q.size(); f0 = ferr_n; v0 = vv_n;
    for (int i = 0; i < VS; i++) ev[i] = 32'h0008_0000;
    send_vec(VS - 1);
    chk("t1_latency_valid", VW'(vec_valid), VW'(1));
    tick(3);
    chk("t1_vec_count", VW'(got_q.size() - b), VW'(1));
    if (got_q.size() > b) chk("t1_data", got_q[b], {VS{32'h0008_0000}});
    chk("t1_valid_cycles", VW'(vv_n - v0), VW'(1));
    chk("t1_no_frame_err", VW'(ferr_n - f0), VW'(0));

    // ---- ordering and sign, back-to-back ----
    b = got_q.size();
    for (int i = 0; i < VS; i++) ev[i] = BW'(i) << 20;
    exp_a = pack_ev();
    send_vec(VS - 1);
    for (int i = 0; i < VS; i++) ev[i] = 32'hFFF8_0000;
    send_vec(VS - 1);
    tick(3);
    chk("t2_vec_count", VW'(got_q.size() - b), VW'(2));
    if (got_q.size() >= b + 2) begin
      t = got_q[b];
      chk("t2_field0_msb", VW'(t[VW-1 -: BW]), VW'(0));
      chk("t2_field19_lsb", VW'(t[BW-1:0]), VW'(32'h0130_0000));
      chk("t2_ramp", t, exp_a);
      chk("t2_neg_half", got_q[b+1], {VS{32'hFFF8_0000}});
      chk("t2_vec_spacing", VW'(got_cyc[b+1] - got_cyc[b]), VW'(VS));
    end

    // ---- backpressure ----
    vec_ready = 1'b0;
    b = got_q.size();
    for (int i = 0; i < VS; i++) ev[i] = 32'h8000_0000 | BW'(i);
    exp_a = pack_ev();
    send_vec(VS - 1);
    for (int i = 0; i < VS; i++) ev[i] = 32'h0010_0000 * BW'(i + 1);
    exp_b = pack_ev();
    send_vec(VS - 1);
    chk("t3_ready_low", VW'(s_ready), VW'(0));
    tick(3);
    chk("t3_ready_still_low", VW'(s_ready), VW'(0));
    chk("t3_hold_valid", VW'(vec_valid), VW'(1));
    chk("t3_hold_bus", vec_bus, exp_a);
    vec_ready = 1'b1;
    tick(3);
    chk("t3_vec_count", VW'(got_q.size() - b), VW'(2));
    if (got_q.size() >= b + 2) begin
      chk("t3_first", got_q[b], exp_a);
      chk("t3_second", got_q[b+1], exp_b);
      chk("t3_back_to_back", VW'(got_cyc[b+1] - got_cyc[b]), VW'(1));
    end
    chk("t3_ready_back", VW'(s_ready), VW'(1));

    // ---- early last ----
    b = got_q.size(); f0 = ferr_n; v0 = vv_n;
    for (int i = 0; i <= 5; i++) send(32'h0A0A_0000 + BW'(i), i == 5);
    tick(1);
    chk("t4_frame_err_pulse", VW'(ferr_n - f0), VW'(1));
    chk("t4_frame_err_low", VW'(frame_err), VW'(0));
    chk("t4_elem_count", VW'(elem_count), VW'(0));
    chk("t4_no_valid", VW'(vv_n - v0), VW'(0));
    for (int i = 0; i < VS; i++) ev[i] = 32'hC000_0000 + (BW'(i) << 8);
    exp_a = pack_ev();
    send_vec(VS - 1);
    tick(3);
    chk("t4_vec_count", VW'(got_q.size() - b), VW'(1));
    if (got_q.size() > b) chk("t4_clean", got_q[b], exp_a);
    chk("t4_frame_err_total", VW'(ferr_n - f0), VW'(1));

    // ---- missing last ----
    b = got_q.size(); f0 = ferr_n;
    for (int i = 0; i < VS; i++) ev[i] = 32'h7FFF_0000 - BW'(i);
    send_vec(-1);
    tick(1);
    chk("t5_frame_err_pulse", VW'(ferr_n - f0), VW'(1));
    chk("t5_no_vec", VW'(got_q.size() - b), VW'(0));
    chk("t5_elem_count", VW'(elem_count), VW'(0));
    for (int i = 0; i < VS; i++) ev[i] = 32'h1234_0000 ^ BW'(i * 3);
    exp_a = pack_ev();
    send_vec(VS - 1);
    tick(3);
    chk("t5_vec_count", VW'(got_q.size() - b), VW'(1));
    if (got_q.size() > b) chk("t5_good", got_q[b], exp_a);

    // ---- reset mid-fill ----
    for (int i = 0; i < 7; i++) send(32'hDEAD_0000 + BW'(i), 1'b0);
    chk("t6_elem_count_7", VW'(elem_count), VW'(7));
    rst = 1'b1;
    tick(1);
    chk("t6_vec_valid", VW'(vec_valid), VW'(0));
    chk("t6_vec_bus", vec_bus, VW'(0));
    chk("t6_elem_count", VW'(elem_count), VW'(0));
    chk("t6_s_ready", VW'(s_ready), VW'(0));
    rst = 1'b0;
    b = got_q.size();
    for (int i = 0; i < VS; i++) ev[i] = 32'h0005_0000 + BW'(i);
    exp_a = pack_ev();
    send_vec(VS - 1);
    tick(3);
    chk("t6_vec_count", VW'(got_q.size() - b), VW'(1));
    if (got_q.size() > b) chk("t6_from_elem0", got_q[b], exp_a);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
